shake256_squeeze: RTL

Squeeze stage of the SHAKE256 datapath. It takes each permuted 1600-bit state string S and emits the first RATE bits as a stream of W-bit output words over a valid/ready handshake until the requested output length is reached. Whenever more output is needed than one block holds, it hands the state back to the Keccak-f permutation and waits for the next S. It sits directly downstream of the 3-D-array-to-string conversion.

---
 rtl/shake256_squeeze.sv | 120 ++++++++++++
 1 files changed

// File: rtl/shake256_squeeze.sv
// shake256_squeeze: squeeze stage of SHAKE256. Streams the first RATE bits of each
// permuted state as W-bit words and hands the state back for another permutation when needed.
module shake256_squeeze #(
    parameter int RATE  = 1088,
    parameter int W     = 64,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] out_len,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [1599:0]    s_in,
    output logic             perm_req,
    output logic [1599:0]    perm_state,
    output logic [W-1:0]     m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             busy,
    output logic             done
);

    localparam int NWORDS = RATE / W;
    localparam logic [4:0] LAST_IDX = 5'(NWORDS - 1);
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    typedef enum logic [1:0] {IDLE, WAIT_S, OUT, PERM} state_t;

    state_t           state;
    state_t           state_nx;
    logic [1599:0]    state_q;
    logic [4:0]       idx;
    logic [LEN_W-1:0] rem;
    logic             done_q;
    logic [W-1:0]     words [NWORDS];

    // Only the rate portion is ever addressable as output words.
    for (genvar g = 0; g < NWORDS; g++) begin : g_word
        assign words[g] = state_q[g*W +: W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (start && out_len != '0) state_nx = WAIT_S;
            WAIT_S: if (s_valid) state_nx = OUT;
            OUT: begin
                if (m_ready) begin
                    if (rem == ONE)           state_nx = IDLE;
                    else if (idx == LAST_IDX) state_nx = PERM;
                end
            end
            PERM:    state_nx = WAIT_S;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            idx     <= '0;
            rem     <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (out_len == '0) done_q <= 1'b1;
                        else               rem    <= out_len;
                    end
                end
                WAIT_S: begin
                    if (s_valid) begin
                        state_q <= s_in;
                        idx     <= '0;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        // idx wraps at the block end so it never exceeds the last lane
                        idx <= (idx == LAST_IDX) ? '0 : idx + 5'd1;
                        rem <= rem - ONE;
                        if (rem == ONE) done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s_ready  = 1'b0;
        m_valid  = 1'b0;
        m_data   = '0;
        m_last   = 1'b0;
        perm_req = 1'b0;
        case (state)
            WAIT_S: s_ready = 1'b1;
            OUT: begin
                m_valid = 1'b1;
                m_data  = words[idx];
                m_last  = (rem == ONE);
            end
            PERM:    perm_req = 1'b1;
            default: ;
        endcase
        busy       = (state != IDLE);
        done       = done_q;
        perm_state = state_q;
    end

endmodule
